// File: rtl/axis_argmax_if.sv
// rtl/axis_argmax_if.sv - AXI-stream style handshake bundle used by axis_argmax
interface axis_argmax_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_argmax.sv
// rtl/axis_argmax.sv - streaming argmax over K signed logits, one result beat per vector
module axis_argmax #(
  parameter int W  = 16,
  parameter int K  = 10,
  parameter int IW = $clog2(K)
) (
  input  logic         aclk,
  input  logic         areset,
  axis_argmax_if.slave  axis_in,
  axis_argmax_if.master axis_out,
  output logic         error
);

  localparam logic [IW:0] CNT_K    = (IW + 1)'(K);
  localparam logic [IW:0] CNT_LAST = (IW + 1)'(K - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                state_q, state_d;
  logic [IW:0]           cnt_q, cnt_d;
  logic signed [W-1:0]   max_q, max_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [W+IW-1:0]       out_data_q, out_data_d;
  logic                  error_q, error_d;

  logic                  in_fire;
  logic                  out_fire;
  logic signed [W-1:0]   beat_max;
  logic [IW-1:0]         beat_idx;

  // Input is only stalled while a result is held and downstream is not taking it
  assign axis_in.tready  = !((state_q == HOLD) && !axis_out.tready);
  assign in_fire         = axis_in.tvalid && axis_in.tready;
  assign out_fire        = (state_q == HOLD) && axis_out.tready;

  assign axis_out.tvalid = (state_q == HOLD);
  assign axis_out.tlast  = (state_q == HOLD);
  assign axis_out.tdata  = out_data_q;
  assign error           = error_q;

  // Next-state: a tlast handshake always (re)fills the result register, even while draining
  always_comb begin
    state_d = state_q;
    if (in_fire && axis_in.tlast) begin
      state_d = HOLD;
    end else if (out_fire) begin
      state_d = ACCUM;
    end
  end

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Running compare: first beat seeds, later beats replace only when strictly greater,
  // beats past K are ignored by the compare and flag a framing error
  always_comb begin
    beat_max   = max_q;
    beat_idx   = idx_q;
    cnt_d      = cnt_q;
    max_d      = max_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    error_d    = error_q;

    if (cnt_q == '0) begin
      beat_max = axis_in.tdata;
      beat_idx = '0;
    end else if ((cnt_q < CNT_K) && ($signed(axis_in.tdata) > max_q)) begin
      beat_max = axis_in.tdata;
      beat_idx = cnt_q[IW-1:0];
    end

    if (in_fire) begin
      max_d = beat_max;
      idx_d = beat_idx;
      if (cnt_q >= CNT_K) begin
        error_d = 1'b1;
      end
      if (axis_in.tlast) begin
        cnt_d      = '0;
        out_data_d = {beat_max, beat_idx};
        if (cnt_q < CNT_LAST) begin
          error_d = 1'b1;
        end
      end else if (cnt_q < CNT_K) begin
        cnt_d = cnt_q + (IW + 1)'(1);
      end
    end
  end

  // Datapath registers; error stays set until reset
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q      <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      error_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_axis_argmax.sv
// tb/tb_axis_argmax.sv - directed self-checking bench for axis_argmax
module tb_axis_argmax;
  localparam int W  = 16;
  localparam int K  = 10;
  localparam int IW = 4;

  typedef logic [W-1:0] vec_t [12];

  logic clk = 1'b0;
  logic rst;
  logic err;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int acc_cyc   = 0;
  int first_acc = 0;
  int timeouts  = 0;

  logic [W+IW-1:0] res_q[$];
  int              rcyc_q[$];

  axis_argmax_if #(.DW(W))      in_if ();
  axis_argmax_if #(.DW(W + IW)) out_if ();

  axis_argmax #(.W(W), .K(K), .IW(IW)) dut (
    .aclk     (clk),
    .areset   (rst),
    .axis_in  (in_if),
    .axis_out (out_if),
    .error    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records every result beat that will transfer on the next edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
        res_q.push_back(out_if.tdata);
        rcyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic put(input logic [W-1:0] d, input logic l);
    int g;
    @(negedge clk);
    in_if.tdata  = d;
    in_if.tvalid = 1'b1;
    in_if.tlast  = l;
    #1;
    g = 0;
    while (in_if.tready !== 1'b1 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 100) timeouts++;
    acc_cyc = cyc + 1;
  endtask

  task automatic send_vec(input vec_t v, input int n);
    for (int i = 0; i < n; i++) begin
      put(v[i], (i == n - 1));
      if (i == 0) first_acc = acc_cyc;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_results();
    res_q.delete();
    rcyc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_results();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_if.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", out_if.tvalid); end
    n_tests++;
    if (out_if.tdata !== 20'h0) begin n_fail++; $display("FAIL reset_tdata: got %h expected 00000", out_if.tdata); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", err); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_in_tready: got %b expected 1", in_if.tready); end
  endtask

  task automatic test_single();
    vec_t v;
    v = '{-16'sd5, 16'sd3, 16'sd12, 16'sd7, 16'sd0, -16'sd1, 16'sd2, 16'sd11, 16'sd4, 16'sd1, 16'sd0, 16'sd0};
    clear_results();
    send_vec(v, 10);
    idle();
    settle();
    n_tests++;
    if (res_q.size() != 1) begin
      n_fail++; $display("FAIL single_count: got %0d expected 1", res_q.size());
    end else begin
      n_tests++;
      if (res_q[0] !== 20'h000C2) begin n_fail++; $display("FAIL single_data: got %h expected 000c2", res_q[0]); end
      n_tests++;
      if (rcyc_q[0] != acc_cyc) begin n_fail++; $display("FAIL single_latency: got cycle %0d expected %0d", rcyc_q[0], acc_cyc); end
    end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL single_error: got %b expected 0", err); end
  endtask

  task automatic test_tie_negative();
    vec_t v;
    clear_results();
    v = '{16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd9, 16'sd0, 16'sd0};
    send_vec(v, 10);
    idle();
    v = '{-16'sd100, -16'sd50, -16'sd20, -16'sd9, -16'sd7, -16'sd4, -16'sd3, -16'sd8, 16'h8000, -16'sd3, 16'sd0, 16'sd0};
    send_vec(v, 10);
    idle();
    settle();
    n_tests++;
    if (res_q.size() != 2) begin
      n_fail++; $display("FAIL tie_count: got %0d expected 2", res_q.size());
    end else begin
      n_tests++;
      if (res_q[0] !== 20'h00090) begin n_fail++; $display("FAIL tie_data: got %h expected 00090", res_q[0]); end
      n_tests++;
      if (res_q[1] !== 20'hFFFD6) begin n_fail++; $display("FAIL negative_data: got %h expected fffd6", res_q[1]); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b, c;
    int start;
    a = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9, 16'sd10, 16'sd0, 16'sd0};
    b = '{16'sd10, 16'sd9, 16'sd8, 16'sd7, 16'sd6, 16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1, 16'sd0, 16'sd0};
    c = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd1, 16'sd32767, 16'sd0, 16'sd5, 16'sd32767, 16'sd0, 16'sd0};
    clear_results();
    send_vec(a, 10);
    start = first_acc;
    send_vec(b, 10);
    send_vec(c, 10);
    idle();
    settle();
    n_tests++;
    if (acc_cyc - start != 29) begin n_fail++; $display("FAIL b2b_no_bubbles: got span %0d expected 29", acc_cyc - start); end
    n_tests++;
    if (res_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 3", res_q.size());
    end else begin
      n_tests++;
      if (res_q[0] !== 20'h000A9) begin n_fail++; $display("FAIL b2b_data0: got %h expected 000a9", res_q[0]); end
      n_tests++;
      if (res_q[1] !== 20'h000A0) begin n_fail++; $display("FAIL b2b_data1: got %h expected 000a0", res_q[1]); end
      n_tests++;
      if (res_q[2] !== 20'h7FFF6) begin n_fail++; $display("FAIL b2b_data2: got %h expected 7fff6", res_q[2]); end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (rcyc_q[k] != start + 9 + 10 * k) begin
          n_fail++; $display("FAIL b2b_cycle%0d: got %0d expected %0d", k, rcyc_q[k], start + 9 + 10 * k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t v1, v2;
    int bad;
    v1 = '{16'sd3, 16'sd1, 16'sd4, 16'sd1, 16'sd5, 16'sd9, 16'sd2, 16'sd6, 16'sd5, 16'sd3, 16'sd0, 16'sd0};
    v2 = '{16'sd2, 16'sd7, 16'sd1, 16'sd8, 16'sd2, 16'sd8, 16'sd1, 16'sd8, 16'sd2, 16'sd8, 16'sd0, 16'sd0};
    clear_results();
    bad = 0;
    out_if.tready = 1'b0;
    send_vec(v1, 10);
    fork
      begin
        send_vec(v2, 10);
        idle();
      end
      begin
        repeat (15) begin
          @(negedge clk);
          #2;
          if (out_if.tvalid !== 1'b1 || out_if.tdata !== 20'h00095 || in_if.tready !== 1'b0) bad++;
        end
        @(negedge clk);
        out_if.tready = 1'b1;
      end
    join
    settle();
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d bad cycles expected 0", bad); end
    n_tests++;
    if (res_q.size() != 2) begin
      n_fail++; $display("FAIL bp_count: got %0d expected 2", res_q.size());
    end else begin
      n_tests++;
      if (res_q[0] !== 20'h00095) begin n_fail++; $display("FAIL bp_data0: got %h expected 00095", res_q[0]); end
      n_tests++;
      if (res_q[1] !== 20'h00083) begin n_fail++; $display("FAIL bp_data1: got %h expected 00083", res_q[1]); end
    end
  endtask

  task automatic test_first_beat_last();
    vec_t v;
    v = '{-16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    clear_results();
    send_vec(v, 1);
    idle();
    settle();
    n_tests++;
    if (res_q.size() != 1) begin
      n_fail++; $display("FAIL first_last_count: got %0d expected 1", res_q.size());
    end else begin
      n_tests++;
      if (res_q[0] !== 20'hFFF90) begin n_fail++; $display("FAIL first_last_data: got %h expected fff90", res_q[0]); end
    end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL first_last_error: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid_vector();
    vec_t v;
    clear_results();
    put(16'd100, 1'b0);
    put(16'd200, 1'b0);
    put(16'd300, 1'b0);
    put(16'd400, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    settle();
    n_tests++;
    if (res_q.size() != 0) begin n_fail++; $display("FAIL midreset_no_output: got %0d beats expected 0", res_q.size()); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL midreset_error_cleared: got %b expected 0", err); end
    v = '{16'sd5, -16'sd5, 16'sd6, -16'sd6, 16'sd7, -16'sd7, 16'sd8, -16'sd8, 16'sd4, -16'sd4, 16'sd0, 16'sd0};
    send_vec(v, 10);
    idle();
    settle();
    n_tests++;
    if (res_q.size() != 1) begin
      n_fail++; $display("FAIL midreset_count: got %0d expected 1", res_q.size());
    end else begin
      n_tests++;
      if (res_q[0] !== 20'h00086) begin n_fail++; $display("FAIL midreset_data: got %h expected 00086", res_q[0]); end
    end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL midreset_error: got %b expected 0", err); end
  endtask

  task automatic test_long_vector();
    vec_t v;
    v = '{16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd50, 16'sd4, 16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd100, 16'sd200};
    clear_results();
    send_vec(v, 12);
    idle();
    settle();
    n_tests++;
    if (res_q.size() != 1) begin
      n_fail++; $display("FAIL long_count: got %0d expected 1", res_q.size());
    end else begin
      n_tests++;
      if (res_q[0] !== 20'h00324) begin n_fail++; $display("FAIL long_data: got %h expected 00324", res_q[0]); end
    end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL long_error: got %b expected 1", err); end
  endtask

  task automatic test_short_framing();
    vec_t v;
    do_reset();
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL short_pre_error: got %b expected 0", err); end
    v = '{16'sd1, 16'sd5, 16'sd2, 16'sd8, 16'sd3, 16'sd4, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    send_vec(v, 6);
    idle();
    settle();
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL short_error: got %b expected 1", err); end
    v = '{-16'sd5, 16'sd3, 16'sd12, 16'sd7, 16'sd0, -16'sd1, 16'sd2, 16'sd11, 16'sd4, 16'sd1, 16'sd0, 16'sd0};
    send_vec(v, 10);
    idle();
    settle();
    n_tests++;
    if (res_q.size() != 2) begin
      n_fail++; $display("FAIL short_count: got %0d expected 2", res_q.size());
    end else begin
      n_tests++;
      if (res_q[0] !== 20'h00083) begin n_fail++; $display("FAIL short_data: got %h expected 00083", res_q[0]); end
      n_tests++;
      if (res_q[1] !== 20'h000C2) begin n_fail++; $display("FAIL short_recovery_data: got %h expected 000c2", res_q[1]); end
    end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL short_error_sticky: got %b expected 1", err); end
  endtask

  task automatic test_no_stall();
    n_tests++;
    if (timeouts != 0) begin n_fail++; $display("FAIL input_stall_timeout: got %0d timeouts expected 0", timeouts); end
  endtask

  initial begin
    rst           = 1'b1;
    in_if.tdata   = '0;
    in_if.tvalid  = 1'b0;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b1;
    test_reset();
    test_single();
    test_tie_negative();
    test_back_to_back();
    test_backpressure();
    test_first_beat_last();
    test_reset_mid_vector();
    test_long_vector();
    test_short_framing();
    test_no_stall();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_argmax.md
Name: axis_argmax

Overview:
- Classifier stage directly downstream of the final dense layer ("dense_6", Linear activation) in the MNIST MLP pipeline.
- Consumes the stream of K signed fixed-point logits for one image and emits one AXI-stream beat per image. The beat carries the index of the largest logit and its value.
- Gives the host/DMA a one-word classification result instead of K raw logits.

Parameters:
- W, 16, bit width of each signed logit on axis_in_tdata (two's complement).
- K, 10, logits per vector (number of classes).
- IW, $clog2(K), width of the class-index field (4 for K=10).

Ports:
- aclk  input  1  clock; all logic is rising-edge.
- areset  input  1  asynchronous, active-high reset.
- axis_in_tdata  input  W  signed logit, one per beat.
- axis_in_tvalid  input  1  upstream beat valid.
- axis_in_tready  output  1  this block can accept a beat.
- axis_in_tlast  input  1  marks the last logit of a vector.
- axis_out_tdata  output  W+IW  {max_val[W-1:0], max_idx[IW-1:0]}.
- axis_out_tvalid  output  1  result valid.
- axis_out_tready  input  1  downstream accepts the result.
- axis_out_tlast  output  1  always equal to axis_out_tvalid (one-beat packets).
- error  output  1  sticky framing-error flag.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - axis_out_tvalid=0, axis_out_tdata=0, error=0, beat counter=0, running max=0, running index=0, FSM=ACCUM.
  - Reset mid-vector discards the partial vector; no output beat is produced for it.
- Input handshake: a beat transfers when axis_in_tvalid && axis_in_tready.
  - axis_in_tready = !(axis_out_tvalid && !axis_out_tready).
  - The block stalls input only while an unconsumed result is held.
- Output handshake:
  - axis_out_tvalid and axis_out_tdata stay stable until axis_out_tvalid && axis_out_tready.
  - tvalid deasserts the cycle after the transfer, unless a new result is loaded in that same cycle.
- FSM states:
  - ACCUM: counting and comparing beats.
  - HOLD: result register full, awaiting tready.
  - ACCUM->HOLD on the tlast handshake.
  - HOLD->ACCUM on the output handshake.
  - HOLD and ACCUM overlap when the output transfer and a new input beat occur in the same cycle. The counter accepts the next vector's first beat while HOLD drains.
- Per accepted beat at counter c:
  - c==0: load max=tdata, idx=0.
  - c>0: if signed(tdata) > max (strictly greater), load max=tdata, idx=c.
  - Ties keep the lowest index.
  - Comparison is a full W-bit signed compare. No saturation or rescaling is applied.
- Counter: width IW+1. Increments per accepted beat, saturates at K, returns to 0 on the tlast handshake.
- Latency: the result is visible on axis_out_tdata with axis_out_tvalid=1 in the cycle after the tlast beat is accepted (1 cycle). The tlast beat itself participates in the compare.
- Throughput: one logit per cycle sustained when axis_out_tready=1. Back-to-back vectors need no idle cycles.
- Boundary conditions:
  - tlast at c<K-1 (short vector): emit result over the beats received; set error.
  - c reaches K without tlast (long vector): further beats are accepted but not compared; error set on the first excess beat; result emitted at tlast.
  - tlast on the first beat with K>1: result {tdata,0}; error set.
  - Output handshake and tlast handshake in the same cycle: the new result is loaded and tvalid stays 1.
  - error is sticky until areset; it never blocks data flow.

Test Plan:
- Single vector, logits {-5,3,12,7,0,-1,2,11,4,1}, tready=1 -> one output beat one cycle after tlast; max_idx=2, max_val=12, error=0.
- Tie: {9,9,...,9} for all 10 logits -> max_idx=0, max_val=9; all-negative {-100,...,-3 at idx 6,...} -> max_idx=6, max_val=-3 (signed compare; -3 must beat 0x8000).
- Back-to-back 3 vectors with tvalid continuous, tready=1 -> 30 consecutive input handshakes, 3 results at cycles 10,20,30 after start, correct indices, no bubbles.
- Backpressure: axis_out_tready=0 for 15 cycles after first result -> tdata/tvalid stable, axis_in_tready=0 while held; second vector completes after release with no lost beats.
- Framing: tlast on beat 6 -> result over 6 beats, error=1 and stays 1; a later good vector still produces a correct result.
- areset asserted after 4 beats of a vector -> no output beat; the next full vector yields the correct result, error=0.
